// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs NBYTES-wide add/sub/logic ops on an 8-bit ALU,
// one byte per cycle LSB first, with carry chaining and C/Z/N/V flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op, opa, opb request; op 000 ADD 001 ADC 010 SUB 011 SBC
//                       100 AND 101 OR 110 XOR 111 illegal
//   ready, done, err    handshake: ready in IDLE, done one-cycle pulse,
//                       err with done for an illegal op
//   result, flag_*      result register and persistent flags
//   alu_*               drive to / response from the 8-bit ALU
//
// Optional feature macro: ALU_SEQ_OVF_EN (signed overflow flag_v).
module alu_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [8*NBYTES-1:0]   result,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_v,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_carry_in,
    output logic                  alu_is_shift,
    output logic [1:0]            alu_scode,
    output logic [2:0]            alu_acode,
    input  logic [7:0]            alu_r,
    input  logic                  alu_carry_out
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    result_q;
    logic [2:0]      op_q;
    logic            chain_q;
    logic            zacc_q;
    logic            fc_q;
    logic            fz_q;
    logic            fn_q;
    logic            done_q;
    logic            err_q;

    logic            is_arith;
    logic            is_sub;
    logic            first;
    logic            last;
    logic            cin_first;
    logic            zacc_d;
    logic [W-1:0]    result_d;

    assign is_arith = ~op_q[2];
    assign is_sub   = ~op_q[2] & op_q[1];
    assign first    = (cnt_q == '0);
    assign last     = (cnt_q == CW'(NBYTES - 1));
    // ADD:0, SUB:1, ADC/SBC: chain in the stored carry flag
    assign cin_first = op_q[0] ? fc_q : op_q[1];

    // Operands are shifted right each byte, so byte i is always in [7:0].
    always_comb begin
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_acode    = 3'b000;
        alu_carry_in = 1'b0;
        if (state_q == S_RUN) begin
            alu_a        = a_q[7:0];
            alu_b        = is_sub ? ~b_q[7:0] : b_q[7:0];
            alu_acode    = is_arith ? 3'b001 : op_q;
            alu_carry_in = is_arith & (first ? cin_first : chain_q);
        end
    end

    assign alu_is_shift = 1'b0;
    assign alu_scode    = 2'b00;

    assign zacc_d   = (alu_r == 8'h00) & (first | zacc_q);
    assign result_d = (result_q >> 8) | (W'(alu_r) << (W - 8));

`ifdef ALU_SEQ_OVF_EN
    logic fv_q;
    logic ovf;
    // On the top byte alu_a/alu_b carry A[W-1] and Beff[W-1].
    assign ovf = is_arith & (alu_a[7] == alu_b[7]) & (alu_r[7] != alu_a[7]);
    always_ff @(posedge clk) begin
        if (rst) begin
            fv_q <= 1'b0;
        end else if (state_q == S_RUN && last) begin
            fv_q <= ovf;
        end
    end
    assign flag_v = fv_q;
`else
    assign flag_v = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            op_q     <= 3'b000;
            chain_q  <= 1'b0;
            zacc_q   <= 1'b0;
            fc_q     <= 1'b0;
            fz_q     <= 1'b0;
            fn_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (start) begin
                        if (op == 3'b111) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            a_q     <= opa;
                            b_q     <= opb;
                            op_q    <= op;
                            cnt_q   <= '0;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    a_q      <= a_q >> 8;
                    b_q      <= b_q >> 8;
                    result_q <= result_d;
                    chain_q  <= alu_carry_out;
                    zacc_q   <= zacc_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        fz_q    <= zacc_d;
                        fn_q    <= alu_r[7];
                        if (is_arith) begin
                            fc_q <= alu_carry_out;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign flag_c = fc_q;
    assign flag_z = fz_q;
    assign flag_n = fn_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl with a
// behavioural 8-bit ALU and a whole-word reference model.
module tb_alu_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
`ifdef ALU_SEQ_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  opa = '0;
    logic [W-1:0]  opb = '0;
    logic          ready, done, err;
    logic [W-1:0]  result;
    logic          flag_c, flag_z, flag_n, flag_v;
    logic [7:0]    alu_a, alu_b;
    logic          alu_carry_in, alu_is_shift;
    logic [1:0]    alu_scode;
    logic [2:0]    alu_acode;
    logic [7:0]    alu_r;
    logic          alu_carry_out;

    alu_seq_ctrl #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .opa(opa), .opb(opb), .ready(ready), .done(done), .err(err),
        .result(result), .flag_c(flag_c), .flag_z(flag_z),
        .flag_n(flag_n), .flag_v(flag_v),
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_is_shift(alu_is_shift), .alu_scode(alu_scode),
        .alu_acode(alu_acode), .alu_r(alu_r),
        .alu_carry_out(alu_carry_out)
    );

    // Behavioural 8-bit ALU
    always_comb begin
        logic [8:0] s;
        s = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
        alu_r = 8'h00;
        alu_carry_out = 1'b0;
        case (alu_acode)
            3'b001: begin alu_r = s[7:0]; alu_carry_out = s[8]; end
            3'b100: alu_r = alu_a & alu_b;
            3'b101: alu_r = alu_a | alu_b;
            3'b110: alu_r = alu_a ^ alu_b;
            default: alu_r = 8'h00;
        endcase
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad = 0;

    logic [W-1:0] mres = '0;
    logic mc = 0, mz = 0, mn = 0, mv = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want none");
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("flags_cznv", {flag_c, flag_z, flag_n, flag_v}, e.fl);
                chk("err", err, e.err);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic model(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, output exp_t x);
        logic [W:0]   s;
        logic [W-1:0] be;
        x.err = 1'b0;
        if (o == 3'b111) begin
            x.err = 1'b1;
        end else if (o[2] == 1'b0) begin
            be = o[1] ? ~b : b;
            if (o[0]) s = {1'b0, a} + {1'b0, be} + W'(mc);
            else      s = {1'b0, a} + {1'b0, be} + W'(o[1]);
            mres = s[W-1:0];
            mc   = s[W];
            mv   = OVF && (a[W-1] == be[W-1]) && (mres[W-1] != a[W-1]);
        end else begin
            case (o)
                3'b100: mres = a & b;
                3'b101: mres = a | b;
                default: mres = a ^ b;
            endcase
            mv = 1'b0;
        end
        if (o != 3'b111) begin
            mz = (mres == '0);
            mn = mres[W-1];
        end
        x.res = mres;
        x.fl  = {mc, mz, mn, mv};
        x.cyc = 0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        exp_t x;
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", ready, 1);
        end
        model(o, a, b, x);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        #1;
        x.cyc = cyc + ((o == 3'b111) ? 0 : NB);
        sb.push_back(x);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_c, flag_z, flag_n, flag_v}, 0);
        chk("rst_alu_drive", {alu_a, alu_b, alu_acode, alu_carry_in}, 0);
        chk("rst_alu_const", {alu_is_shift, alu_scode}, 0);
        rst = 1'b0;

        issue(3'b000, 32'h0000_00FF, 32'h0000_0001);
        @(negedge clk);
        chk("ready_in_run", ready, 0);
        chk("acode_in_run", alu_acode, 3'b001);
        drain();
        chk("add_result", result, 32'h0000_0100);
        chk("idle_alu_drive", {alu_a, alu_b, alu_acode, alu_carry_in}, 0);

        issue(3'b010, 32'h0000_0000, 32'h0000_0001);
        drain();
        chk("sub_result", result, 32'hFFFF_FFFF);
        chk("sub_c_n", {flag_c, flag_n}, 2'b01);
        issue(3'b011, 32'h0000_0005, 32'h0000_0001);
        drain();
        chk("sbc_result", result, 32'h0000_0003);
        chk("sbc_c", flag_c, 1);

        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(3'b001, 32'h0000_0000, 32'h0000_0000);
        drain();
        chk("adc_result", result, 32'h0000_0001);

        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(3'b110, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        issue(3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
        drain();
        chk("illegal_keeps_cz", {flag_c, flag_z}, 2'b11);

        // start held through RUN and DONE must not queue a second op
        issue(3'b000, 32'h0102_0304, 32'h1111_1111);
        start = 1'b1;
        op = 3'b000;
        repeat (NB + 1) @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // reset in the second RUN cycle aborts without done
        issue(3'b000, 32'h0000_0001, 32'h0000_0002);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mres = '0; mc = 0; mz = 0; mn = 0; mv = 0;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_result", result, 0);
        chk("abort_flags", {flag_c, flag_z, flag_n, flag_v}, 0);
        repeat (8) @(negedge clk);

        issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
        drain();
        chk("ovf_add_v", flag_v, OVF);
        chk("ovf_add_res", result, 32'h8000_0000);
        issue(3'b010, 32'h8000_0000, 32'h0000_0001);
        drain();
        chk("ovf_sub_v", flag_v, OVF);
        chk("ovf_sub_res", result, 32'h7FFF_FFFF);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer that runs multi-byte (NBYTES x 8-bit) arithmetic/logic operations on the existing 8-bit combinational ALU, one byte per cycle, LSB first.
- Chains carry between bytes, keeps persistent C/Z/N flags, and exposes a start/done handshake to the datapath control.
- Sits between the control unit and the ALU instance; owns the ALU's A/B/carry_in/acode/is_shift inputs while active.

Parameters:
NBYTES, 4, operand width in bytes (>=1); operand width W = 8*NBYTES

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only when ready=1
op  in  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 illegal
opa  in  W  operand A, captured on accepted start
opb  in  W  operand B, captured on accepted start
ready  out  1  high in IDLE
done  out  1  one-cycle pulse, result/flags valid
err  out  1  with done: illegal op
result  out  W  result register, held until next accepted op
flag_c  out  1  carry flag (SUB/SBC: 1 = no borrow)
flag_z  out  1  zero flag (whole W-bit result)
flag_n  out  1  result[W-1]
flag_v  out  1  signed overflow (see Optional Feature)
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_carry_in  out  1  to ALU carry_in
alu_is_shift  out  1  to ALU is_shift, constant 0
alu_scode  out  2  to ALU scode, constant 00
alu_acode  out  3  to ALU acode
alu_r  in  8  from ALU R
alu_carry_out  in  1  from ALU carry_out

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE, ready=1, done=0, err=0, result=0, all flags=0, byte counter=0, ALU drive outputs=0. rst mid-RUN aborts; no done pulse.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: ready=1. start=1 at edge with legal op: capture opa/opb/op, counter=0, go RUN. Illegal op (111): go DONE with err=1; result and flags unchanged.
- RUN: byte i (counter) presented combinationally on alu_a=A[8i+7:8i] and alu_b, with alu_r and alu_carry_out captured at the end of the same cycle. Counter increments; after byte NBYTES-1 go DONE.
- DONE: done=1 for exactly one cycle; result/flags already updated; next state IDLE. start during RUN/DONE is ignored (not queued).
- Latency: start accepted at edge k -> done high in cycle k+NBYTES+1. Next start accepted no earlier than the edge ending the DONE+1 (IDLE) cycle.
- Arithmetic mapping (alu_acode=001 for all arithmetic bytes):
  - ADD: alu_b=B byte, cin byte0=0.
  - ADC: alu_b=B byte, cin byte0=flag_c.
  - SUB: alu_b=~B byte (inverted by controller), cin byte0=1.
  - SBC: alu_b=~B byte, cin byte0=flag_c.
  - Bytes i>0: cin=alu_carry_out captured from byte i-1 (internal chain register).
  - flag_c=carry_out of byte NBYTES-1.
- Logic ops: alu_acode=100/101/110, alu_b=B byte, alu_carry_in=0; flag_c unchanged.
- flag_z=1 iff all NBYTES result bytes are zero (accumulated AND of per-byte zero); flag_n=result[W-1]; both updated for every legal op.
- alu_a/alu_b/alu_acode/alu_carry_in=0 outside RUN.

Optional Feature:
- Macro ALU_SEQ_OVF_EN.
- Defined: flag_v updated on ADD/ADC/SUB/SBC. Value = (A[W-1] == Beff[W-1]) && (result[W-1] != A[W-1]), where Beff is the B actually presented to the ALU (inverted for SUB/SBC). Logic ops clear flag_v; reset clears it.
- Undefined: flag_v tied 0; no extra registers.

Test Plan:
- ADD opa=0x000000FF, opb=0x00000001 (NBYTES=4) -> result 0x00000100, C=0, Z=0, N=0; done exactly 5 cycles after start edge; ready=0 during RUN.
- SUB 0x00000000 - 0x00000001 -> 0xFFFFFFFF, C=0 (borrow), N=1, Z=0; then SBC 0x00000005 - 0x00000001 with C=0 -> 0x00000003, C=1.
- Set C=1 via ADD 0xFFFFFFFF+1 (result 0, C=1, Z=1); then ADC 0x00000000+0x00000000 -> 0x00000001, C=0, Z=0.
- XOR 0xA5A5A5A5^0xA5A5A5A5 after a C=1 op -> 0, Z=1, C stays 1; op=111 -> done+err 1 cycle after start, result/flags unchanged.
- start re-asserted during RUN -> ignored, single done; rst asserted in 2nd RUN cycle -> no done, result=0, flags=0, ready=1 next cycle.
- With ALU_SEQ_OVF_EN: ADD 0x7FFFFFFF+1 -> 0x80000000, V=1, N=1; SUB 0x80000000-1 -> 0x7FFFFFFF, V=1; without macro, V=0 in both.
